charmem_arbiter: RTL and testbench

- Owns the single-port, synchronous-read character RAM behind the HDMI text console.
- Shares that RAM between three requesters:
  - the HDMI text renderer (hard real-time reads);
  - the CPU memory-mapped port (stallable reads and writes);
  - an internal fill engine that clears or fills the whole screen with one character.
- Sits between the text-console RAM, the renderer and the SoC bus decoder.

---
 rtl/charmem_pkg.sv | 25 ++
 rtl/charmem_fill_engine.sv | 82 ++++++++
 rtl/charmem_arbiter.sv | 126 ++++++++++++
 tb/tb_charmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// charmem_pkg : shared types and geometry for the character RAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package charmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_FILL = 2'd3
    } owner_t;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

    localparam int unsigned DEF_COLS = 80;
    localparam int unsigned DEF_ROWS = 30;
    localparam int unsigned CELLS    = DEF_COLS * DEF_ROWS;

endpackage
`default_nettype wire

// File: rtl/charmem_fill_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// charmem_fill_engine : walks every cell once, writing a latched character
// Rev 1.0
// ---------------------------------------------------------------------------
module charmem_fill_engine
    import charmem_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 12,
    parameter int unsigned         DATA_W    = 8,
    parameter logic [ADDR_W-1:0]   LAST_CELL = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] start_char,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] char_q, char_d;
    logic              last_q, last_d;
    logic              done_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL_IDLE;
            cnt_q   <= '0;
            char_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            last_q  <= last_d;
            done_q  <= last_q;
        end
    end

    // Counter only moves on a granted write and stops at the last cell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        last_d  = 1'b0;
        case (state_q)
            FILL_IDLE: begin
                if (start) begin
                    state_d = FILL_RUN;
                    cnt_d   = '0;
                    char_d  = start_char;
                end
            end
            FILL_RUN: begin
                if (grant) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = FILL_IDLE;
                        last_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    assign busy = (state_q == FILL_RUN);
    assign req  = busy;
    assign addr = cnt_q;
    assign data = char_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/charmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// charmem_arbiter : shares the text-console character RAM between video,
//                   CPU and the fill engine (priority video > CPU > fill)
// Rev 1.0
// ---------------------------------------------------------------------------
module charmem_arbiter
    import charmem_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_char,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    owner_t            grant;
    owner_t            tag_q, tag_d;
    logic              cpu_oor, cpu_oor_q;
    logic              cpu_elig;
    logic              cpu_ready_q;
    logic              vid_rvalid_q;
    logic              fill_req;
    logic              fill_grant;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    assign cpu_oor  = (cpu_addr > LAST_CELL);
    // A completing CPU transaction must not be granted a second time.
    assign cpu_elig = cpu_valid && !vid_req && !cpu_ready_q;

    always_comb begin
        grant     = OWN_NONE;
        tag_d     = OWN_NONE;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (vid_req) begin
            grant    = OWN_VID;
            tag_d    = OWN_VID;
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (cpu_elig) begin
            grant = OWN_CPU;
            if (!cpu_we) begin
                tag_d = OWN_CPU;
            end
            if (!cpu_oor) begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
        end else if (fill_req) begin
            grant     = OWN_FILL;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fill_addr;
            mem_wdata = fill_data;
        end
    end

    assign fill_grant = (grant == OWN_FILL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q        <= OWN_NONE;
            cpu_ready_q  <= 1'b0;
            cpu_oor_q    <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            cpu_ready_q  <= (grant == OWN_CPU);
            cpu_oor_q    <= (grant == OWN_CPU) && cpu_oor;
            vid_rvalid_q <= (grant == OWN_VID);
        end
    end

    assign vid_rvalid = vid_rvalid_q;
    assign vid_rdata  = (tag_q == OWN_VID) ? mem_rdata : '0;
    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = (cpu_ready_q && tag_q == OWN_CPU && !cpu_oor_q) ? mem_rdata : '0;

    charmem_fill_engine #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LAST_CELL (LAST_CELL)
    ) u_fill (
        .clk        (clk),
        .resetn     (resetn),
        .start      (fill_start),
        .start_char (fill_char),
        .grant      (fill_grant),
        .req        (fill_req),
        .addr       (fill_addr),
        .data       (fill_data),
        .busy       (fill_busy),
        .done       (fill_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_charmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_charmem_arbiter : directed self-checking bench with a behavioural RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_charmem_arbiter;
    import charmem_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NC = CELLS;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_char = '0;
    logic          fill_busy;
    logic          fill_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    int            wr2d_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (mem_en && mem_we && mem_wdata == 8'h2D) wr2d_cnt <= wr2d_cnt + 1;
    end

    charmem_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .fill_start (fill_start),
        .fill_char  (fill_char),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one CPU transaction, giving up after a few cycles.
    task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            output logic [DW-1:0] rd, output logic ok);
        ok = 1'b0;
        rd = '0;
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_ready) begin
                rd = cpu_rdata;
                ok = 1'b1;
                break;
            end
        end
        cpu_valid = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        resetn = 1'b0;
        step();
        outs = {mem_en, mem_we, vid_rvalid, cpu_ready, fill_busy, fill_done, |mem_addr};
        checks++;
        if (outs !== 7'b0 || vid_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b vid_rdata=%h cpu_rdata=%h expected all 0", outs, vid_rdata, cpu_rdata);
        end
        resetn = 1'b1;
        step(); step(); step();
        outs = {mem_en, mem_we, vid_rvalid, cpu_ready, fill_busy, fill_done, |mem_addr};
        checks++;
        if (outs !== 7'b0 || vid_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL idle_outputs: got ctl=%b vid_rdata=%h cpu_rdata=%h expected all 0", outs, vid_rdata, cpu_rdata);
        end
    endtask

    task automatic test_cpu_rw();
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd5; cpu_wdata = 8'h41;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'd5, 8'h41}) begin
            errors++;
            $display("FAIL cpu_write_grant: got en=%b we=%b addr=%0d data=%h expected 1 1 5 41", mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL cpu_write_ready: got %b expected 1", cpu_ready);
        end
        cpu_valid = 1'b0; cpu_we = 1'b0;
        step();
        cpu_valid = 1'b1; cpu_addr = 12'd5;
        #1;
        checks++;
        if ({mem_en, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL cpu_read_grant: got en=%b we=%b expected 1 0", mem_en, mem_we);
        end
        step();
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h41) begin
            errors++;
            $display("FAIL cpu_read_data: got ready=%b rdata=%h expected 1 41", cpu_ready, cpu_rdata);
        end
        cpu_valid = 1'b0;
        step();
    endtask

    task automatic test_collision();
        logic [DW-1:0] rd;
        logic          ok;
        cpu_xfer(1'b1, 12'd7, 8'h20, rd, ok);
        step();
        vid_req = 1'b1; vid_addr = 12'd7;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd7;
        step();
        vid_req = 1'b0;
        checks++;
        if (vid_rvalid !== 1'b1 || vid_rdata !== 8'h20 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_video: got rvalid=%b rdata=%h cpu_ready=%b expected 1 20 0", vid_rvalid, vid_rdata, cpu_ready);
        end
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 12'd7) begin
            errors++;
            $display("FAIL collision_cpu_grant: got en=%b addr=%0d expected 1 7", mem_en, mem_addr);
        end
        step();
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h20 || vid_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL collision_cpu: got ready=%b rdata=%h vid_rvalid=%b expected 1 20 0", cpu_ready, cpu_rdata, vid_rvalid);
        end
        cpu_valid = 1'b0;
        step();
    endtask

    task automatic test_fill();
        int   nwr = 0;
        int   ndone = 0;
        int   done_at = -1;
        logic seq_bad = 1'b0;
        logic busy_first = 1'b0;
        logic busy_after = 1'b1;
        fill_char = 8'h2E; fill_start = 1'b1;
        step();
        fill_start = 1'b0; fill_char = 8'h00;
        for (int i = 0; i < 2410; i++) begin
            #1;
            if (mem_en && mem_we) begin
                if (mem_addr != AW'(nwr) || mem_wdata != 8'h2E) seq_bad = 1'b1;
                nwr++;
            end
            if (fill_done) begin
                ndone++;
                done_at = i;
            end
            if (i == 0)    busy_first = fill_busy;
            if (i == 2400) busy_after = fill_busy;
            step();
        end
        checks++;
        if (nwr != NC || seq_bad) begin
            errors++;
            $display("FAIL fill_writes: got %0d writes (order_bad=%b) expected %0d in order", nwr, seq_bad, NC);
        end
        checks++;
        if (ndone != 1 || done_at != NC + 1) begin
            errors++;
            $display("FAIL fill_done_timing: got %0d pulses at offset %0d expected 1 at %0d", ndone, done_at, NC + 1);
        end
        checks++;
        if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL fill_busy: got first=%b after=%b expected 1 0", busy_first, busy_after);
        end
        vid_req = 1'b1; vid_addr = 12'd2399;
        step();
        vid_req = 1'b0;
        checks++;
        if (vid_rvalid !== 1'b1 || vid_rdata !== 8'h2E) begin
            errors++;
            $display("FAIL fill_last_cell: got rvalid=%b rdata=%h expected 1 2e", vid_rvalid, vid_rdata);
        end
        step();
    endtask

    task automatic test_fill_contention();
        logic [DW-1:0] rd;
        logic          ok;
        int            base;
        logic          seen = 1'b0;
        base = wr2d_cnt;
        fill_char = 8'h2D; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        cpu_xfer(1'b1, 12'd3, 8'h58, rd, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contention_wr3: got no ready expected ready"); end
        cpu_xfer(1'b1, 12'd2000, 8'h58, rd, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contention_wr2000: got no ready expected ready"); end
        step(); step();
        fill_start = 1'b1; fill_char = 8'h77;
        step();
        fill_start = 1'b0;
        #1;
        checks++;
        if (mem_addr !== AW'(wr2d_cnt - base) || mem_wdata !== 8'h2D || fill_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_restart_ignored: got addr=%0d data=%h busy=%b expected %0d 2d 1", mem_addr, mem_wdata, fill_busy, wr2d_cnt - base);
        end
        for (int i = 0; i < 3000 && !seen; i++) begin
            step();
            if (fill_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL contention_done: got no fill_done expected pulse"); end
        step();
        cpu_xfer(1'b0, 12'd2000, 8'h00, rd, ok);
        checks++;
        if (!ok || rd !== 8'h2D) begin
            errors++;
            $display("FAIL contention_addr2000: got ok=%b data=%h expected 1 2d", ok, rd);
        end
        cpu_xfer(1'b0, 12'd3, 8'h00, rd, ok);
        checks++;
        if (!ok || rd !== 8'h58) begin
            errors++;
            $display("FAIL contention_addr3: got ok=%b data=%h expected 1 58", ok, rd);
        end
        cpu_xfer(1'b0, 12'd2399, 8'h00, rd, ok);
        checks++;
        if (!ok || rd !== 8'h2D) begin
            errors++;
            $display("FAIL contention_addr2399: got ok=%b data=%h expected 1 2d", ok, rd);
        end
    endtask

    task automatic test_oor_and_reset();
        int npulse = 0;
        int nbusy = 0;
        step();
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd2400;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_mem_en: got %b expected 0", mem_en);
        end
        step();
        cpu_valid = 1'b0;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL oor_read: got ready=%b rdata=%h expected 1 00", cpu_ready, cpu_rdata);
        end
        step();
        fill_char = 8'h00; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        resetn = 1'b0;
        #1;
        checks++;
        if (fill_busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_midfill: got busy=%b mem_en=%b expected 0 0", fill_busy, mem_en);
        end
        step(); step();
        resetn = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            step();
            if (fill_done) npulse++;
            if (fill_busy) nbusy++;
        end
        checks++;
        if (npulse != 0 || nbusy != 0) begin
            errors++;
            $display("FAIL reset_abort: got done=%0d busy=%0d cycles expected 0 0", npulse, nbusy);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_collision();
        test_fill();
        test_fill_contention();
        test_oor_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
